// File: rtl/ascii_packer_pkg.sv
// ascii_packer_pkg
// Definitions shared by the packed-ASCII writer (ascii_packer) and the
// transformer read side:
//   - FSM state encoding (IDLE/HI/LO/DONE/CSUM)
//   - the default end-of-line character
//   - the checksum word tag
//   - the byte order of a packed word: first char in [15:8], second in [7:0]
// Helper functions build a packed word and update the running checksum
// and the saturating character count.
package ascii_packer_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_HI   = 3'd1;
   localparam logic [2:0] ST_LO   = 3'd2;
   localparam logic [2:0] ST_DONE = 3'd3;
   localparam logic [2:0] ST_CSUM = 3'd4;

   localparam logic [7:0] TERM_CHAR_DEF = 8'h00;
   localparam logic [7:0] CSUM_TAG      = 8'hC5;
   localparam logic [7:0] PAD_BYTE      = 8'h00;

   // Byte lanes of a packed word
   localparam int WORD_HI_MSB = 15;
   localparam int WORD_HI_LSB = 8;
   localparam int WORD_LO_MSB = 7;
   localparam int WORD_LO_LSB = 0;

   function automatic logic [15:0] pack_word(input logic [7:0] hi, input logic [7:0] lo);
      logic [15:0] w;
      w = 16'h0000;
      w[WORD_HI_MSB:WORD_HI_LSB] = hi;
      w[WORD_LO_MSB:WORD_LO_LSB] = lo;
      return w;
   endfunction

   function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] c);
      return acc ^ c;
   endfunction

   function automatic logic [7:0] len_inc_sat(input logic [7:0] n);
      return (n == 8'hFF) ? n : n + 8'h01;
   endfunction

endpackage

// File: rtl/ascii_packer_if.sv
// ascii_packer_if
// Bundle of the packer's handshake, memory-write and line-report signals.
//   master : host/loader + memory side (drives line_start/char_in/char_valid)
//   slave  : the packer itself
// Signals:
//   line_start, char_in[7:0], char_valid, char_ready   character stream
//   mem_we, mem_addr[ADDR_W-1:0], mem_din[15:0]         memory write port
//   line_done, line_ptr[ADDR_W-1:0], line_len[7:0]      line report
//   full, checksum[7:0]                                 status
interface ascii_packer_if #(
   parameter int ADDR_W = 10
);
   logic              line_start;
   logic [7:0]        char_in;
   logic              char_valid;
   logic              char_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_din;
   logic              line_done;
   logic [ADDR_W-1:0] line_ptr;
   logic [7:0]        line_len;
   logic              full;
   logic [7:0]        checksum;

   modport master (
      output line_start, char_in, char_valid,
      input  char_ready, mem_we, mem_addr, mem_din,
      input  line_done, line_ptr, line_len, full, checksum
   );

   modport slave (
      input  line_start, char_in, char_valid,
      output char_ready, mem_we, mem_addr, mem_din,
      output line_done, line_ptr, line_len, full, checksum
   );
endinterface

// File: rtl/ascii_packer_wr.sv
// ascii_packer_wr
// Registered memory write stage of the packer: owns the write pointer,
// the sticky full flag and the mem_we/mem_addr/mem_din registers.
// Ports:
//   clk, rst_n                clock, async active-low reset
//   wr_req, wr_data[15:0]     write wr_data at the current pointer
//   rewind, rewind_addr       move the pointer back (abandoned line)
//   wp                        current write pointer
//   wr_last                   pointer sits on the last memory address
//   full                      last address has been written (sticky)
//   mem_we/mem_addr/mem_din   registered memory write port
module ascii_packer_wr #(
   parameter int                ADDR_W    = 10,
   parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_req,
   input  logic [15:0]       wr_data,
   input  logic              rewind,
   input  logic [ADDR_W-1:0] rewind_addr,
   output logic [ADDR_W-1:0] wp,
   output logic              wr_last,
   output logic              full,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_din
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [ADDR_W-1:0] wp_q, wp_d;
   logic              full_q, full_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [15:0]       mem_din_q, mem_din_d;

   // Next-state of the write port; the pointer never wraps: the write to
   // the last address raises full and leaves the pointer where it is.
   always_comb begin
      wp_d       = wp_q;
      full_d     = full_q;
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      if (rewind) begin
         wp_d = rewind_addr;
      end else if (wr_req && !full_q) begin
         mem_we_d   = 1'b1;
         mem_addr_d = wp_q;
         mem_din_d  = wr_data;
         if (wp_q == LAST_ADDR) begin
            full_d = 1'b1;
         end else begin
            wp_d = wp_q + ADDR_ONE;
         end
      end else begin
         wp_d = wp_q;
      end
   end

   // Write port registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q       <= BASE_ADDR;
         full_q     <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= BASE_ADDR;
         mem_din_q  <= 16'h0000;
      end else begin
         wp_q       <= wp_d;
         full_q     <= full_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
      end
   end

   assign wp       = wp_q;
   assign wr_last  = (wp_q == LAST_ADDR);
   assign full     = full_q;
   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;

endmodule

// File: rtl/ascii_packer.sv
// ascii_packer
// Packs a byte-serial ASCII stream two characters per 16-bit word and
// writes the words to the character memory at sequential addresses,
// reporting start pointer and length of each completed line.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bus (slave)  line_start/char_in/char_valid/char_ready stream,
//                mem_we/mem_addr/mem_din write port,
//                line_done/line_ptr/line_len report, full, checksum
// Build option: ASCII_PACKER_CHECKSUM_EN appends a {C5, xor} word after
// each line's terminator word and reports the xor on checksum.
module ascii_packer
   import ascii_packer_pkg::*;
#(
   parameter int                ADDR_W    = 10,
   parameter logic [7:0]        TERM_CHAR = TERM_CHAR_DEF,
   parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
   input  logic         clk,
   input  logic         rst_n,
   ascii_packer_if.slave bus
);

`ifdef ASCII_PACKER_CHECKSUM_EN
   localparam logic [2:0] TAIL_STATE = ST_CSUM;
`else
   localparam logic [2:0] TAIL_STATE = ST_DONE;
`endif

   logic [2:0]        state_q, state_d;
   logic [7:0]        hi_byte_q, hi_byte_d;
   logic [ADDR_W-1:0] line_base_q, line_base_d;
   logic [7:0]        count_q, count_d;
   logic [7:0]        xor_q, xor_d;
   logic              line_done_q, line_done_d;
   logic [ADDR_W-1:0] line_ptr_q, line_ptr_d;
   logic [7:0]        line_len_q, line_len_d;
   logic [7:0]        checksum_q, checksum_d;

   logic              start_s;
   logic              char_ready_s;
   logic              accept_s;
   logic              is_term_s;
   logic              wr_req_s;
   logic [15:0]       wr_data_s;
   logic              rewind_s;
   logic [ADDR_W-1:0] wp_s;
   logic              wr_last_s;
   logic              full_s;

   assign start_s      = bus.line_start;
   assign char_ready_s = ((state_q == ST_HI) || (state_q == ST_LO)) && !full_s;
   // line_start wins over a character on the same cycle; the character is dropped
   assign accept_s     = bus.char_valid && char_ready_s && !start_s;
   assign is_term_s    = (bus.char_in == TERM_CHAR);

   // Line FSM; a write that lands on the last address ends the line without
   // a report because the memory is now full.
   always_comb begin
      state_d     = state_q;
      hi_byte_d   = hi_byte_q;
      line_base_d = line_base_q;
      count_d     = count_q;
      xor_d       = xor_q;
      line_done_d = 1'b0;
      line_ptr_d  = line_ptr_q;
      line_len_d  = line_len_q;
      checksum_d  = checksum_q;
      wr_req_s    = 1'b0;
      wr_data_s   = 16'h0000;
      rewind_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               line_base_d = wp_s;
               count_d     = 8'h00;
               xor_d       = 8'h00;
               state_d     = ST_HI;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HI, ST_LO: begin
            if (start_s) begin
               // abandon: rewind to the line start and begin again
               rewind_s  = 1'b1;
               hi_byte_d = 8'h00;
               count_d   = 8'h00;
               xor_d     = 8'h00;
               state_d   = ST_HI;
            end else if (accept_s) begin
               if (state_q == ST_HI) begin
                  hi_byte_d = bus.char_in;
                  if (is_term_s) begin
                     wr_req_s  = 1'b1;
                     wr_data_s = pack_word(TERM_CHAR, PAD_BYTE);
                     state_d   = wr_last_s ? ST_IDLE : TAIL_STATE;
                  end else begin
                     count_d = len_inc_sat(count_q);
                     xor_d   = csum_update(xor_q, bus.char_in);
                     state_d = ST_LO;
                  end
               end else begin
                  wr_req_s  = 1'b1;
                  wr_data_s = pack_word(hi_byte_q, bus.char_in);
                  if (is_term_s) begin
                     state_d = wr_last_s ? ST_IDLE : TAIL_STATE;
                  end else begin
                     count_d = len_inc_sat(count_q);
                     xor_d   = csum_update(xor_q, bus.char_in);
                     state_d = wr_last_s ? ST_IDLE : ST_HI;
                  end
               end
            end else begin
               state_d = state_q;
            end
         end
`ifdef ASCII_PACKER_CHECKSUM_EN
         ST_CSUM: begin
            wr_req_s  = 1'b1;
            wr_data_s = pack_word(CSUM_TAG, xor_q);
            state_d   = wr_last_s ? ST_IDLE : ST_DONE;
         end
`endif
         ST_DONE: begin
            line_done_d = 1'b1;
            line_ptr_d  = line_base_q;
            line_len_d  = count_q;
`ifdef ASCII_PACKER_CHECKSUM_EN
            checksum_d  = xor_q;
`else
            checksum_d  = 8'h00;
`endif
            state_d     = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM and line-report registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         hi_byte_q   <= 8'h00;
         line_base_q <= BASE_ADDR;
         count_q     <= 8'h00;
         xor_q       <= 8'h00;
         line_done_q <= 1'b0;
         line_ptr_q  <= BASE_ADDR;
         line_len_q  <= 8'h00;
         checksum_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         hi_byte_q   <= hi_byte_d;
         line_base_q <= line_base_d;
         count_q     <= count_d;
         xor_q       <= xor_d;
         line_done_q <= line_done_d;
         line_ptr_q  <= line_ptr_d;
         line_len_q  <= line_len_d;
         checksum_q  <= checksum_d;
      end
   end

   ascii_packer_wr #(
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE_ADDR)
   ) u_wr (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_req      (wr_req_s),
      .wr_data     (wr_data_s),
      .rewind      (rewind_s),
      .rewind_addr (line_base_q),
      .wp          (wp_s),
      .wr_last     (wr_last_s),
      .full        (full_s),
      .mem_we      (bus.mem_we),
      .mem_addr    (bus.mem_addr),
      .mem_din     (bus.mem_din)
   );

   assign bus.char_ready = char_ready_s;
   assign bus.full       = full_s;
   assign bus.line_done  = line_done_q;
   assign bus.line_ptr   = line_ptr_q;
   assign bus.line_len   = line_len_q;
   assign bus.checksum   = checksum_q;

endmodule

// File: tb/tb_ascii_packer.sv
// tb_ascii_packer
// Drives two packers (ADDR_W=10 and ADDR_W=2) and compares every memory
// write and line report against a reference built from the line text.
module tb_ascii_packer;

`ifdef ASCII_PACKER_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       ls    = 1'b0;
   logic       cval  = 1'b0;
   logic       sel   = 1'b0;
   logic [7:0] cin   = 8'h00;
   int         cyc   = 0;
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ascii_packer_if #(.ADDR_W(10)) bi ();
   ascii_packer_if #(.ADDR_W(2))  si ();

   assign bi.line_start = ls & ~sel;
   assign bi.char_in    = cin;
   assign bi.char_valid = cval & ~sel;
   assign si.line_start = ls & sel;
   assign si.char_in    = cin;
   assign si.char_valid = cval & sel;

   wire rdy = sel ? si.char_ready : bi.char_ready;

   ascii_packer #(.ADDR_W(10)) dut   (.clk(clk), .rst_n(rst_n), .bus(bi));
   ascii_packer #(.ADDR_W(2))  dut_s (.clk(clk), .rst_n(rst_n), .bus(si));

   typedef struct {int cyc; int addr; logic [15:0] din; logic full;} wr_t;
   typedef struct {int cyc; int ptr; int len; logic [7:0] cs;} dn_t;

   wr_t wlog[$];
   dn_t dlog[$];
   int  acc_q[$];

   always @(negedge clk) begin : monitor
      wr_t w;
      dn_t d;
      if (bi.mem_we) begin
         w.cyc = cyc; w.addr = int'(bi.mem_addr); w.din = bi.mem_din; w.full = bi.full;
         wlog.push_back(w);
      end
      if (si.mem_we) begin
         w.cyc = cyc; w.addr = int'(si.mem_addr); w.din = si.mem_din; w.full = si.full;
         wlog.push_back(w);
      end
      if (bi.line_done) begin
         d.cyc = cyc; d.ptr = int'(bi.line_ptr); d.len = int'(bi.line_len); d.cs = bi.checksum;
         dlog.push_back(d);
      end
      if (si.line_done) begin
         d.cyc = cyc; d.ptr = int'(si.line_ptr); d.len = int'(si.line_len); d.cs = si.checksum;
         dlog.push_back(d);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_pulse(input logic with_char, input logic [7:0] c);
      @(negedge clk);
      ls = 1'b1; cval = with_char; cin = c;
      @(negedge clk);
      ls = 1'b0; cval = 1'b0;
   endtask

   // mode 0: valid held, 1: valid toggles, 2: random valid
   task automatic send(input logic [7:0] q[$], input int mode, input int budget, output int n_acc);
      int   i = 0;
      int   t = 0;
      logic v;
      while (i < q.size() && t < budget) begin
         @(negedge clk);
         case (mode)
            0:       v = 1'b1;
            1:       v = (t[0] == 1'b0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         cval = v;
         cin  = v ? q[i] : 8'($urandom);
         #1;
         if (v && rdy) begin
            acc_q.push_back(cyc);
            i++;
         end
         t++;
      end
      @(negedge clk);
      cval = 1'b0;
      n_acc = i;
   endtask

   // Reference: words are consecutive character pairs of the line (terminator
   // included, odd count padded with 00), each written the cycle after the
   // accept of its last character; optional checksum word follows.
   task automatic check_line(input logic [7:0] q[$], input int base, output int next_base);
      wr_t        e[$];
      wr_t        w;
      int         n;
      int         lidx;
      logic [7:0] x;
      n = q.size();
      x = 8'h00;
      next_base = base;
      chk("accepted", acc_q.size(), n);
      if (acc_q.size() == n) begin
         for (int j = 0; 2 * j < n; j++) begin
            lidx   = (2 * j + 1 < n) ? 2 * j + 1 : 2 * j;
            w.addr = base + j;
            w.din  = {q[2 * j], (2 * j + 1 < n) ? q[2 * j + 1] : 8'h00};
            w.cyc  = acc_q[lidx] + 1;
            w.full = 1'b0;
            e.push_back(w);
         end
         for (int k = 0; k < n - 1; k++) x = x ^ q[k];
         if (CS == 1) begin
            w.addr = base + e.size();
            w.din  = {8'hC5, x};
            w.cyc  = acc_q[n - 1] + 2;
            e.push_back(w);
         end
         chk("wr_count", wlog.size(), e.size());
         for (int k = 0; k < e.size() && k < wlog.size(); k++) begin
            chk("wr_addr", wlog[k].addr, e[k].addr);
            chk("wr_din", {16'h0000, wlog[k].din}, {16'h0000, e[k].din});
            chk("wr_cycle", wlog[k].cyc, e[k].cyc);
         end
         chk("done_count", dlog.size(), 1);
         if (dlog.size() > 0) begin
            chk("line_ptr", dlog[0].ptr, base);
            chk("line_len", dlog[0].len, (n - 1 > 255) ? 255 : n - 1);
            chk("checksum", {24'h0, dlog[0].cs}, {24'h0, (CS == 1) ? x : 8'h00});
            chk("done_cycle", dlog[0].cyc, acc_q[n - 1] + 2 + CS);
         end
         next_base = base + e.size();
      end
      wlog.delete();
      dlog.delete();
      acc_q.delete();
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [7:0] q[$];
      int         base;
      int         nacc;
      int         len;
      int         b2;

      // reset values
      #1 rst_n = 1'b0;
      #2;
      chk("rst_ready", bi.char_ready, 0);
      chk("rst_we", bi.mem_we, 0);
      chk("rst_addr", bi.mem_addr, 0);
      chk("rst_din", bi.mem_din, 0);
      chk("rst_done", bi.line_done, 0);
      chk("rst_ptr", bi.line_ptr, 0);
      chk("rst_len", bi.line_len, 0);
      chk("rst_full", bi.full, 0);
      chk("rst_csum", bi.checksum, 0);
      chk("rst_full_s", si.full, 0);
      idle(3);
      rst_n = 1'b1;
      idle(2);

      // characters in IDLE are refused
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); cval = 1'b1; cin = 8'h5A; #1;
         chk("idle_ready", rdy, 0);
      end
      @(negedge clk); cval = 1'b0;
      idle(2);
      chk("idle_writes", wlog.size(), 0);

      base = 0;
      q = '{8'h73, 8'h5E, 8'h32, 8'h00};
      start_pulse(1'b0, 8'h00);
      send(q, 0, 40, nacc);
      idle(5);
      if (wlog.size() > 1) begin
         chk("s2_word0", wlog[0].din, 16'h735E);
         chk("s2_word1", wlog[1].din, 16'h3200);
      end
      check_line(q, base, base);

      q = '{8'h61, 8'h62, 8'h00};
      start_pulse(1'b0, 8'h00);
      send(q, 1, 40, nacc);
      idle(5);
      check_line(q, base, base);

      q = '{8'h41, 8'h42, 8'h00};
      start_pulse(1'b0, 8'h00);
      send(q, 0, 40, nacc);
      idle(5);
      check_line(q, base, base);

      // random lines, toggled / random valid
      for (int r = 0; r < 6; r++) begin
         len = $urandom_range(0, 12);
         q.delete();
         for (int k = 0; k < len; k++) q.push_back(8'($urandom_range(1, 255)));
         q.push_back(8'h00);
         start_pulse(1'b0, 8'h00);
         send(q, 1 + (r % 2), q.size() * 6 + 40, nacc);
         idle(5);
         check_line(q, base, base);
      end

      // long line: length saturates at 255
      q.delete();
      for (int k = 0; k < 300; k++) q.push_back(8'($urandom_range(1, 255)));
      q.push_back(8'h00);
      start_pulse(1'b0, 8'h00);
      send(q, 0, 400, nacc);
      idle(5);
      check_line(q, base, base);

      // abandon after "xy","z"; restart pulse carries a character that is dropped
      q = '{8'h78, 8'h79, 8'h7A};
      start_pulse(1'b0, 8'h00);
      send(q, 0, 40, nacc);
      start_pulse(1'b1, 8'h77);
      q = '{8'h71, 8'h00};
      send(q, 0, 40, nacc);
      idle(5);
      chk("rw_count", wlog.size(), 2);
      if (wlog.size() == 2) begin
         chk("rw_addr0", wlog[0].addr, base);
         chk("rw_din0", wlog[0].din, 16'h7879);
         chk("rw_addr1", wlog[1].addr, base);
         chk("rw_din1", wlog[1].din, 16'h7100);
      end
      b2 = base + 1 + CS;
      chk("rw_done", dlog.size(), 1);
      if (dlog.size() == 1) begin
         chk("rw_ptr", dlog[0].ptr, base);
         chk("rw_len", dlog[0].len, 1);
      end
      base = b2;
      wlog.delete(); dlog.delete(); acc_q.delete();

      // small memory fills up after 8 characters
      sel = 1'b1;
      q.delete();
      for (int k = 0; k < 10; k++) q.push_back(8'h61 + 8'(k));
      start_pulse(1'b0, 8'h00);
      send(q, 0, 20, nacc);
      idle(5);
      chk("full_acc", nacc, 8);
      chk("full_wrs", wlog.size(), 4);
      for (int k = 0; k < 4 && k < wlog.size() && 2 * k + 1 < acc_q.size(); k++) begin
         chk("full_addr", wlog[k].addr, k);
         chk("full_din", wlog[k].din, {q[2 * k], q[2 * k + 1]});
         chk("full_flag", wlog[k].full, (k == 3) ? 1 : 0);
         chk("full_cyc", wlog[k].cyc, acc_q[2 * k + 1] + 1);
      end
      chk("full_sticky", si.full, 1);
      chk("full_ready", rdy, 0);
      chk("full_nodone", dlog.size(), 0);
      start_pulse(1'b0, 8'h00);
      #1 chk("full_ready2", rdy, 0);
      wlog.delete(); dlog.delete(); acc_q.delete();
      sel = 1'b0;

      // asynchronous reset in the middle of a line
      q = '{8'h6D, 8'h6E, 8'h6F};
      start_pulse(1'b0, 8'h00);
      send(q, 0, 40, nacc);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_we", bi.mem_we, 0);
      chk("arst_addr", bi.mem_addr, 0);
      chk("arst_ptr", bi.line_ptr, 0);
      chk("arst_ready", bi.char_ready, 0);
      chk("arst_full_s", si.full, 0);
      idle(2);
      rst_n = 1'b1;
      wlog.delete(); dlog.delete(); acc_q.delete();
      q = '{8'h6B, 8'h00};
      start_pulse(1'b0, 8'h00);
      send(q, 0, 40, nacc);
      idle(5);
      check_line(q, 0, base);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ascii_packer.md
Name: ascii_packer

Overview:
Writer-side counterpart of the character-stream transformer path. It accepts a byte-serial LaTeX ASCII stream over a valid/ready handshake and packs two characters per 16-bit word, in the same format the packed-ASCII character memory stores. It writes each word to memory through a sequential address counter and reports the start pointer and length of each completed line, so the line mapper's pointer table can be built. It sits between a host/loader interface and the character memory's write port.

Parameters:
ADDR_W, 10, memory word-address width
TERM_CHAR, 8'h00, end-of-line character; it is written to memory and ends the line
BASE_ADDR, 0, first word address written after reset

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous assert, active-low
line_start  input  1  one-cycle pulse; begins a new line
char_in  input  8  ASCII character
char_valid  input  1  char_in is valid
char_ready  output  1  packer accepts char_in this cycle
mem_we  output  1  memory write strobe (registered)
mem_addr  output  ADDR_W  word address for the write
mem_din  output  16  packed word: first char in [15:8], second char in [7:0]
line_done  output  1  one-cycle pulse; a line was completed
line_ptr  output  ADDR_W  start word address of the last completed line
line_len  output  8  characters in the last completed line, excluding the terminator; saturates at 255
full  output  1  sticky flag; the last memory address has been written
checksum  output  8  XOR of the last line's characters (optional feature)

Behaviour:
- Reset values: char_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_din=0, line_done=0, line_ptr=BASE_ADDR, line_len=0, full=0, checksum=0, state=IDLE, write pointer wp=BASE_ADDR.
- Handshake: a character is accepted when char_valid && char_ready. char_ready=1 only in states HI and LO with full=0.
- States: IDLE, HI, LO, DONE.
- IDLE: on line_start, latch line_base=wp, clear the character count, go to HI.
- HI: on accept, hold the character in hi_byte.
  - If the character == TERM_CHAR: write {TERM_CHAR, 8'h00} at wp, increment wp, go to DONE.
  - Otherwise go to LO.
- LO: on accept, write {hi_byte, char_in} at wp and increment wp. Go to DONE if the character == TERM_CHAR, else go to HI.
- DONE: for one cycle, pulse line_done, set line_ptr=line_base, set line_len=count. Then go to IDLE.
- Latency:
  - The write (mem_we/mem_addr/mem_din) appears on cycle N+1 after the accepting handshake at cycle N.
  - line_done appears on cycle N+2 after the terminator's handshake.
- Address arithmetic: wp increments mod 2^ADDR_W only while full=0. A write to address 2^ADDR_W-1 sets full on the same cycle as that mem_we. After that, char_ready=0 until reset, with no wrap. A line in progress when full sets never reaches DONE.
- line_start in HI or LO abandons the current line: wp rewinds to line_base, hi_byte is discarded, the state goes to HI, and no line_done is produced. Words already written stay in memory but are overwritten by the new line.
- line_start in DONE is ignored.
- line_start and an accepted character on the same cycle: line_start wins and the character is dropped. char_ready remains 1, so the sender treats the character as consumed.
- Characters presented in IDLE are not accepted.
- line_len counts the accepted non-terminator characters; it holds at 255 once 255 is reached.
- Asynchronous reset mid-line: every register returns to its reset value immediately, and any partial word is lost.

Optional Feature:
ASCII_PACKER_CHECKSUM_EN.
- Defined:
  - A running XOR of the non-terminator characters is kept.
  - In DONE, before line_done, an extra state CSUM writes {8'hC5, xor} at wp and increments wp.
  - line_done is then delayed by one cycle, and checksum = xor.
  - line_len excludes the checksum word.
- Not defined: CSUM does not exist, checksum is tied to 0, and timing is as described above.

Decomposition:
- Shared package: the state encoding (IDLE/HI/LO/DONE/CSUM), TERM_CHAR default, checksum tag 8'hC5, and the packed-word byte-order constants, shared with the transformer read side.
- Sub-module: a natural one is ascii_packer_wr, which holds the registered write-port stage (wp counter, full flag, mem_we/addr/din registers). The FSM stays in the top module.

Test Plan:
- Reset, pulse line_start, stream "s^2",0x00 with valid held -> writes {73,5E}@0, {32,00}@1; line_done with line_ptr=0, line_len=3.
- Then stream "ab",0x00 -> writes {61,62}@2, {00,00}@3; line_ptr=2, line_len=2.
- Toggle char_valid 1/0 every cycle -> identical memory contents; no write occurs in cycles without an accept.
- ADDR_W=2, stream 10 characters -> writes to addresses 0..3, full=1 on the address-3 write, char_ready=0, no line_done.
- line_start after "xy","z" accepted -> wp rewinds to the line_base; the next line "q",0x00 writes {71,00} at line_base; line_done reports that same line_ptr.
- With ASCII_PACKER_CHECKSUM_EN, line "AB",0x00 -> after the terminator word, writes {C5,03}; checksum=8'h03; line_done is one cycle later.
